// File: rtl/keccak_share_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | keccak_share_arbiter_if                                              |
// | Requester, core and digest signals of the shared Keccak arbiter.     |
// | Revision: 1.0                                                        |
// +--------------------------------------------------------------------+
interface keccak_share_arbiter_if;
    logic         req0_valid;
    logic [31:0]  req0_data;
    logic         req0_last;
    logic [1:0]   req0_byte_num;
    logic         req0_ready;

    logic         req1_valid;
    logic [31:0]  req1_data;
    logic         req1_last;
    logic [1:0]   req1_byte_num;
    logic         req1_ready;

    logic         core_reset;
    logic [31:0]  core_in;
    logic         core_in_ready;
    logic         core_is_last;
    logic [1:0]   core_byte_num;
    logic         core_buffer_full;
    logic [511:0] core_out;
    logic         core_out_ready;

    logic [511:0] digest;
    logic         digest_valid;
    logic         digest_id;
    logic         digest_ack;
    logic         busy;

    // Arbiter side
    modport master (
        input  req0_valid, req0_data, req0_last, req0_byte_num,
        output req0_ready,
        input  req1_valid, req1_data, req1_last, req1_byte_num,
        output req1_ready,
        output core_reset, core_in, core_in_ready, core_is_last, core_byte_num,
        input  core_buffer_full, core_out, core_out_ready,
        output digest, digest_valid, digest_id,
        input  digest_ack,
        output busy
    );

    // Requesters, core and digest consumer side
    modport slave (
        output req0_valid, req0_data, req0_last, req0_byte_num,
        input  req0_ready,
        output req1_valid, req1_data, req1_last, req1_byte_num,
        input  req1_ready,
        input  core_reset, core_in, core_in_ready, core_is_last, core_byte_num,
        output core_buffer_full, core_out, core_out_ready,
        input  digest, digest_valid, digest_id,
        output digest_ack,
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/keccak_share_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | keccak_share_arbiter                                                 |
// | Round-robin time-sharing of one keccak core between two requesters.  |
// | Revision: 1.0                                                        |
// +--------------------------------------------------------------------+
module keccak_share_arbiter #(
    parameter int CORE_RST_CYCLES = 1
) (
    input wire clk,
    input wire reset,
    keccak_share_arbiter_if.master bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CRST   = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;
    localparam logic [1:0] S_WAIT   = 2'd3;

    localparam logic [3:0] c_RST_LOAD = CORE_RST_CYCLES[3:0];

    logic [1:0]   r_state;
    logic [1:0]   w_state_nxt;
    logic [3:0]   r_cnt;
    logic [3:0]   w_cnt_nxt;
    // Current owner; only changes on a grant, so it is also the last owner
    logic         r_owner;
    logic         w_grant;
    logic         w_grant_id;
    logic [511:0] r_digest;
    logic         r_digest_valid;
    logic         r_digest_id;

    logic         w_own_valid;
    logic [31:0]  w_own_data;
    logic         w_own_last;
    logic [1:0]   w_own_bn;
    logic         w_stream;
    logic         w_accept;
    logic         w_load;

    assign w_own_valid = r_owner ? bus.req1_valid    : bus.req0_valid;
    assign w_own_data  = r_owner ? bus.req1_data     : bus.req0_data;
    assign w_own_last  = r_owner ? bus.req1_last     : bus.req0_last;
    assign w_own_bn    = r_owner ? bus.req1_byte_num : bus.req0_byte_num;

    assign w_stream = (r_state == S_STREAM);
    assign w_accept = w_stream & w_own_valid & ~bus.core_buffer_full;
    assign w_load   = (r_state == S_WAIT) & bus.core_out_ready &
                      (~r_digest_valid | bus.digest_ack);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_grant     = 1'b0;
        w_grant_id  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.req0_valid | bus.req1_valid) begin
                    w_grant     = 1'b1;
                    w_grant_id  = (bus.req0_valid & bus.req1_valid) ? ~r_owner : bus.req1_valid;
                    w_cnt_nxt   = c_RST_LOAD;
                    w_state_nxt = S_CRST;
                end
            end
            S_CRST: begin
                if (r_cnt <= 4'd1) begin
                    w_state_nxt = S_STREAM;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_STREAM: begin
                if (w_accept & w_own_last) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_load) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_cnt          <= 4'd0;
            r_owner        <= 1'b1;
            r_digest       <= '0;
            r_digest_valid <= 1'b0;
            r_digest_id    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_grant) begin
                r_owner <= w_grant_id;
            end
            // A load in the same cycle as an ack keeps valid high with the new value
            if (w_load) begin
                r_digest       <= bus.core_out;
                r_digest_id    <= r_owner;
                r_digest_valid <= 1'b1;
            end else if (bus.digest_ack) begin
                r_digest_valid <= 1'b0;
            end
        end
    end

    assign bus.req0_ready    = w_stream & ~r_owner & ~bus.core_buffer_full;
    assign bus.req1_ready    = w_stream &  r_owner & ~bus.core_buffer_full;
    assign bus.core_in_ready = w_accept;
    assign bus.core_is_last  = w_stream & w_own_last;
    assign bus.core_in       = w_own_data;
    assign bus.core_byte_num = w_own_bn;
    assign bus.core_reset    = (r_state == S_CRST) | reset;

    assign bus.digest       = r_digest;
    assign bus.digest_valid = r_digest_valid;
    assign bus.digest_id    = r_digest_id;
    assign bus.busy         = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_keccak_share_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_keccak_share_arbiter                                              |
// | Directed bench with a stand-in hashing core and digest scoreboard.   |
// | Revision: 1.0                                                        |
// +--------------------------------------------------------------------+
module tb_keccak_share_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic reset3;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    keccak_share_arbiter_if bus ();
    keccak_share_arbiter_if bus3 ();

    keccak_share_arbiter #(.CORE_RST_CYCLES(1)) u_dut  (.clk(clk), .reset(reset),  .bus(bus));
    keccak_share_arbiter #(.CORE_RST_CYCLES(3)) u_dut3 (.clk(clk), .reset(reset3), .bus(bus3));

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Stand-in hash: order- and count-sensitive fold of every accepted word
    function automatic logic [511:0] mix(input logic [511:0] h, input logic [31:0] w,
                                         input logic last, input logic [1:0] bn);
        logic [511:0] r;
        r        = {h[478:0], h[511:479]};
        r[31:0]  = r[31:0] ^ w;
        r[34:32] = r[34:32] ^ {last, bn};
        return r;
    endfunction

    logic [31:0] msg_w [6][12];
    int          msg_len [6];
    logic [1:0]  msg_bn [6];

    function automatic logic [511:0] msg_hash(input int m);
        logic [511:0] h;
        h = '0;
        for (int i = 0; i < msg_len[m]; i++) begin
            h = mix(h, msg_w[m][i], i == msg_len[m] - 1,
                    (i == msg_len[m] - 1) ? msg_bn[m] : 2'd0);
        end
        return h;
    endfunction

    typedef struct {
        logic         id;
        logic [511:0] h;
    } exp_t;
    exp_t exp_q[$];

    // Stand-in core for the main instance: out_ready 4 cycles after the last word
    logic [511:0] acc = '0;
    int           core_words = 0;
    logic         got_last = 1'b0;
    int           lat = 0;
    always @(posedge clk) begin
        if (bus.core_reset) begin
            acc                <= '0;
            core_words         <= 0;
            got_last           <= 1'b0;
            lat                <= 0;
            bus.core_out_ready <= 1'b0;
        end else begin
            if (bus.core_in_ready) begin
                acc        <= mix(acc, bus.core_in, bus.core_is_last, bus.core_byte_num);
                core_words <= core_words + 1;
                if (bus.core_is_last) got_last <= 1'b1;
            end
            if (got_last && !bus.core_out_ready) begin
                if (lat == 3) bus.core_out_ready <= 1'b1;
                lat <= lat + 1;
            end
        end
    end
    assign bus.core_out = acc;

    logic [511:0] out3 = '0;
    always @(posedge clk) begin
        if (bus3.core_reset) begin
            bus3.core_out_ready <= 1'b0;
            out3                <= '0;
        end else if (bus3.core_in_ready && bus3.core_is_last) begin
            bus3.core_out_ready <= 1'b1;
            out3                <= {480'd0, bus3.core_in};
        end
    end
    assign bus3.core_out = out3;

    int rst_pulses = 0;
    int rst_run    = 0;
    int rst_len    = 0;
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.core_reset) begin
                rst_run = rst_run + 1;
            end else if (rst_run > 0) begin
                rst_pulses = rst_pulses + 1;
                rst_len    = rst_run;
                rst_run    = 0;
            end
        end
    end

    // Compare process: pass-through rules, digest hold, scoreboard consumer
    bit           auto_ack = 1'b1;
    logic         p_valid = 1'b0;
    logic         p_ack = 1'b0;
    logic         p_id = 1'b0;
    logic [511:0] p_digest = '0;
    exp_t         e;
    always @(negedge clk) begin
        if (reset) begin
            p_valid        = 1'b0;
            p_ack          = 1'b0;
            bus.digest_ack = 1'b0;
        end else begin
            chk("one_owner", bus.req0_ready & bus.req1_ready, 0);
            if (bus.core_buffer_full) chk("bp_ready", bus.req0_ready | bus.req1_ready, 0);
            if (bus.req0_ready) begin
                chk("in_ready0", bus.core_in_ready, bus.req0_valid);
                if (bus.req0_valid)
                    chk("pass0", {bus.core_in, bus.core_is_last, bus.core_byte_num},
                                 {bus.req0_data, bus.req0_last, bus.req0_byte_num});
            end else if (bus.req1_ready) begin
                chk("in_ready1", bus.core_in_ready, bus.req1_valid);
                if (bus.req1_valid)
                    chk("pass1", {bus.core_in, bus.core_is_last, bus.core_byte_num},
                                 {bus.req1_data, bus.req1_last, bus.req1_byte_num});
            end else begin
                chk("in_ready_off", {bus.core_in_ready, bus.core_is_last}, 0);
            end
            if (p_valid && !p_ack) begin
                chk("digest_hold", {bus.digest_valid, bus.digest_id, bus.digest},
                                   {1'b1, p_id, p_digest});
            end else if (bus.digest_valid) begin
                chk("digest_is_core_out", bus.digest, bus.core_out);
            end
            if (bus.digest_valid && auto_ack) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_digest", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("digest_id", bus.digest_id, e.id);
                    chk("digest", bus.digest, e.h);
                end
                bus.digest_ack = 1'b1;
            end else begin
                bus.digest_ack = 1'b0;
            end
            p_valid  = bus.digest_valid;
            p_ack    = bus.digest_ack;
            p_id     = bus.digest_id;
            p_digest = bus.digest;
        end
    end

    task automatic set_req(input int k, input logic v, input logic [31:0] d,
                           input logic l, input logic [1:0] b);
        if (k == 0) begin
            bus.req0_valid = v; bus.req0_data = d; bus.req0_last = l; bus.req0_byte_num = b;
        end else begin
            bus.req1_valid = v; bus.req1_data = d; bus.req1_last = l; bus.req1_byte_num = b;
        end
    endtask

    // Streams message m from requester k; stalls counts waits after the first word
    task automatic send(input int k, input int m, output int stalls, output int first_lat,
                        output bit aborted);
        int  p;
        int  n;
        bit  got;
        p         = cyc;
        stalls    = 0;
        first_lat = -1;
        aborted   = 1'b0;
        for (int i = 0; i < msg_len[m]; i++) begin
            set_req(k, 1'b1, msg_w[m][i], i == msg_len[m] - 1,
                    (i == msg_len[m] - 1) ? msg_bn[m] : 2'd0);
            n   = 0;
            got = 1'b0;
            while (!got) begin
                @(negedge clk);
                if (reset) begin
                    set_req(k, 1'b0, 32'd0, 1'b0, 2'd0);
                    aborted = 1'b1;
                    return;
                end
                if ((k == 0) ? bus.req0_ready : bus.req1_ready) begin
                    got = 1'b1;
                    if (i == 0) first_lat = cyc - p;
                end else begin
                    if (i > 0) stalls++;
                    n++;
                    if (n > 1000) begin
                        total++;
                        bad++;
                        $display("FAIL send_timeout: req %0d msg %0d stuck at word %0d", k, m, i);
                        set_req(k, 1'b0, 32'd0, 1'b0, 2'd0);
                        aborted = 1'b1;
                        return;
                    end
                end
            end
            @(posedge clk);
            #1;
        end
        set_req(k, 1'b0, 32'd0, 1'b0, 2'd0);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.busy) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(name, n < 3000, 1);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int st0, st1, la0, la1, pulses0, n, crst3, rdy3;
    bit ab0, ab1;
    initial begin
        msg_len[0] = 4;  msg_bn[0] = 2'd1;
        msg_w[0][0] = 32'h48656C6C; msg_w[0][1] = 32'h6F2C2077;
        msg_w[0][2] = 32'h6F726C64; msg_w[0][3] = 32'h21000000;
        msg_len[1] = 3;  msg_bn[1] = 2'd3;
        msg_w[1][0] = 32'hA0000001; msg_w[1][1] = 32'hA0000002; msg_w[1][2] = 32'hA0000003;
        msg_len[2] = 3;  msg_bn[2] = 2'd2;
        msg_w[2][0] = 32'hB0000001; msg_w[2][1] = 32'hB0000002; msg_w[2][2] = 32'hB0000003;
        msg_len[3] = 12; msg_bn[3] = 2'd0;
        msg_w[3][0] = 32'h54686520; msg_w[3][1] = 32'h71756963; msg_w[3][2]  = 32'h6B206272;
        msg_w[3][3] = 32'h6F776E20; msg_w[3][4] = 32'h666F7820; msg_w[3][5]  = 32'h6A756D70;
        msg_w[3][6] = 32'h73206F76; msg_w[3][7] = 32'h65722074; msg_w[3][8]  = 32'h6865206C;
        msg_w[3][9] = 32'h617A7920; msg_w[3][10] = 32'h646F672E; msg_w[3][11] = 32'h00000000;
        msg_len[4] = 4;  msg_bn[4] = 2'd2;
        msg_w[4][0] = 32'hC0000001; msg_w[4][1] = 32'hC0000002;
        msg_w[4][2] = 32'hC0000003; msg_w[4][3] = 32'hC0000004;

        reset = 1'b1;
        reset3 = 1'b1;
        bus.core_buffer_full = 1'b0;
        bus3.core_buffer_full = 1'b0;
        bus3.digest_ack = 1'b0;
        bus3.req0_valid = 1'b0; bus3.req0_data = 32'd0; bus3.req0_last = 1'b0; bus3.req0_byte_num = 2'd0;
        bus3.req1_valid = 1'b0; bus3.req1_data = 32'd0; bus3.req1_last = 1'b0; bus3.req1_byte_num = 2'd0;

        chk("pin_mix1", mix('0, 32'h12345678, 1'b1, 2'd2), 512'h6_12345678);
        chk("pin_mix2", mix(mix('0, 32'd1, 1'b0, 2'd0), 32'hB, 1'b1, 2'd1), 512'h7_0000000B);

        // Both requesters valid from reset
        set_req(0, 1'b1, msg_w[1][0], 1'b0, 2'd0);
        set_req(1, 1'b1, msg_w[2][0], 1'b0, 2'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_dvalid", bus.digest_valid, 0);
        chk("rst_digest", bus.digest, 0);
        chk("rst_did", bus.digest_id, 0);
        chk("rst_ready", {bus.req0_ready, bus.req1_ready, bus.core_in_ready}, 0);
        chk("rst_core_reset", bus.core_reset, 1);
        exp_q.push_back('{1'b0, msg_hash(1)});
        exp_q.push_back('{1'b1, msg_hash(2)});
        @(posedge clk);
        #1;
        reset  = 1'b0;
        reset3 = 1'b0;
        fork
            send(0, 1, st0, la0, ab0);
            send(1, 2, st1, la1, ab1);
        join
        chk("tie_stalls0", st0, 0);
        drain("tie_drain");

        // Single message
        exp_q.push_back('{1'b0, msg_hash(0)});
        pulses0 = rst_pulses;
        send(0, 0, st0, la0, ab0);
        drain("single_drain");
        chk("single_latency", la0, 2);
        chk("single_stalls", st0, 0);
        chk("single_pulses", rst_pulses - pulses0, 1);
        chk("single_pulse_len", rst_len, 1);
        chk("single_words", core_words, 4);

        // Back-pressure for 5 cycles mid-stream
        exp_q.push_back('{1'b0, msg_hash(3)});
        fork
            send(0, 3, st0, la0, ab0);
            begin
                n = 0;
                while (core_words != 6 && n < 500) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                bus.core_buffer_full = 1'b1;
                repeat (5) @(posedge clk);
                #1;
                bus.core_buffer_full = 1'b0;
            end
        join
        drain("bp_drain");
        chk("bp_stalls", st0, 5);
        chk("bp_words", core_words, 12);

        // Unacknowledged digest blocks the second capture
        auto_ack = 1'b0;
        exp_q.push_back('{1'b0, msg_hash(1)});
        exp_q.push_back('{1'b1, msg_hash(2)});
        send(0, 1, st0, la0, ab0);
        send(1, 2, st1, la1, ab1);
        n = 0;
        while (!bus.core_out_ready && n < 500) begin
            @(posedge clk);
            n++;
        end
        repeat (10) @(posedge clk);
        #1;
        chk("hold_busy", bus.busy, 1);
        chk("hold_dvalid", bus.digest_valid, 1);
        chk("hold_did", bus.digest_id, 0);
        chk("hold_digest", bus.digest, msg_hash(1));
        auto_ack = 1'b1;
        @(posedge clk);
        #1;
        chk("swap_dvalid", bus.digest_valid, 1);
        chk("swap_did", bus.digest_id, 1);
        chk("swap_digest", bus.digest, msg_hash(2));
        drain("hold_drain");

        // Reset after two words, then restart the whole message
        fork
            send(0, 4, st0, la0, ab0);
            begin
                n = 0;
                while (core_words != 2 && n < 500) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                reset = 1'b1;
                @(posedge clk);
                #1;
                reset = 1'b0;
                chk("midrst_busy", bus.busy, 0);
                chk("midrst_dvalid", bus.digest_valid, 0);
            end
        join
        chk("midrst_aborted", ab0, 1);
        exp_q.push_back('{1'b0, msg_hash(4)});
        send(0, 4, st0, la0, ab0);
        drain("midrst_drain");

        // Three-cycle core reset instance
        @(posedge clk);
        #1;
        bus3.req0_valid = 1'b1; bus3.req0_data = 32'hDEADBEEF;
        bus3.req0_last = 1'b1;  bus3.req0_byte_num = 2'd3;
        n     = cyc;
        crst3 = 0;
        rdy3  = -1;
        for (int i = 0; i < 50 && rdy3 < 0; i++) begin
            @(negedge clk);
            if (bus3.core_reset) crst3++;
            if (bus3.req0_ready) rdy3 = cyc - n;
        end
        chk("p3_crst_len", crst3, 3);
        chk("p3_ready_lat", rdy3, 4);
        @(posedge clk);
        #1;
        bus3.req0_valid = 1'b0;
        n = 0;
        while (!bus3.digest_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("p3_dvalid", bus3.digest_valid, 1);
        chk("p3_digest", bus3.digest, {480'd0, 32'hDEADBEEF});
        chk("p3_did", bus3.digest_id, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
